// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the program-counter / fetch-request controller:
// FSM state encoding, redirect-select encodings and the default reset vector.
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StBoot = 2'b00,
    StRun  = 2'b01,
    StHalt = 2'b10
  } pc_state_e;

  // Redir_sel encodings
  localparam logic REDIR_PCREL = 1'b0;  // Redir_base + Imm (branch / JAL)
  localparam logic REDIR_REG   = 1'b1;  // (Rs1 + Imm) & ~1 (JALR)

  // Wide enough for RV64; the top slices it down to XLEN.
  localparam logic [63:0] DEFAULT_RESET_VEC = 64'h0;

endpackage

// File: rtl/pc_fetch_ctrl_target.sv
// Combinational redirect-target calculation: operand mux, adder, JALR bit0 clear
// and the alignment check against IALIGN.
module pc_target_calc
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IALIGN = 4
) (
  input  logic            Redir_sel,
  input  logic [XLEN-1:0] Redir_base,
  input  logic [XLEN-1:0] Imm,
  input  logic [XLEN-1:0] Rs1,
  output logic [XLEN-1:0] Target,
  output logic            Misaligned
);

  // IALIGN is a power of two, so "mod IALIGN" reduces to masking the low bits.
  localparam logic [XLEN-1:0] AlignMask = XLEN'(IALIGN - 1);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] sum;

  always_comb begin
    op_a = Redir_base;
    if (Redir_sel == REDIR_REG) begin
      op_a = Rs1;
    end
  end

  assign sum = op_a + Imm;

  always_comb begin
    Target = sum;
    if (Redir_sel == REDIR_REG) begin
      Target = {sum[XLEN-1:1], 1'b0};
    end
  end

  assign Misaligned = |(Target & AlignMask);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch request controller. Holds the fetch
// address, advances it on ack and applies trap / branch / jump redirects.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned    XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = DEFAULT_RESET_VEC[XLEN-1:0],
  parameter int unsigned    IALIGN    = 4
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Stall,
  input  logic            Redir_valid,
  input  logic            Redir_sel,
  input  logic [XLEN-1:0] Redir_base,
  input  logic [XLEN-1:0] Imm,
  input  logic [XLEN-1:0] Rs1,
  input  logic            Trap_valid,
  input  logic [XLEN-1:0] Trap_vec,
  input  logic            Fetch_ack,
  output logic            Fetch_req,
  output logic [XLEN-1:0] Fetch_addr,
  output logic            Misalign,
  output logic [XLEN-1:0] Misalign_addr
);

  localparam logic [XLEN-1:0] Step = XLEN'(IALIGN);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

  logic [XLEN-1:0] target;
  logic            target_misaligned;

  pc_target_calc #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_target (
    .Redir_sel  (Redir_sel),
    .Redir_base (Redir_base),
    .Imm        (Imm),
    .Rs1        (Rs1),
    .Target     (target),
    .Misaligned (target_misaligned)
  );

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;

    case (state_q)
      StBoot: begin
        state_d = StRun;
      end

      StRun: begin
        if (Trap_valid) begin
          pc_d = Trap_vec;
        end else if (Redir_valid) begin
          if (target_misaligned) begin
            // PC stays on the last good address; fetch waits for the trap.
            misalign_d      = 1'b1;
            misalign_addr_d = target;
            state_d         = StHalt;
          end else begin
            // Any concurrent ack is dropped: the redirect replaces PC + IALIGN.
            pc_d = target;
          end
        end else if (!Stall && Fetch_ack) begin
          pc_d = pc_q + Step;
        end
      end

      StHalt: begin
        if (Trap_valid) begin
          pc_d    = Trap_vec;
          state_d = StRun;
        end
      end

      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q         <= StBoot;
      pc_q            <= RESET_VEC;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign Fetch_req     = (state_q == StRun);
  assign Fetch_addr    = pc_q;
  assign Misalign      = misalign_q;
  assign Misalign_addr = misalign_addr_q;

endmodule
